// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
// One shared shift/add-subtract datapath runs WIDTH iterations per operation.
// MULT/MULTU use shift-add. DIV/DIVU use restoring division.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, op          request + operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   A, B               operands (rs, rt)
//   mthi, mtlo, wdata  direct HI/LO writes, honoured only when idle
//   busy, done         operation in progress / one-cycle result pulse
//   div_by_zero        pulses with done for a divide by zero
//   hi, lo             architectural HI/LO registers
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   opnd_q;   // multiplicand (mult) or divisor (div) magnitude
  logic [2*WIDTH-1:0] acc_q;    // {upper, lower}: product or remainder:quotient
  logic [2*WIDTH-1:0] acc_d;
  logic [CW-1:0]      cnt_q;
  logic               qneg_q;   // product / quotient sign
  logic               rneg_q;   // remainder sign
  logic               bzero_q;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    a_neg = ~op[0] & A[WIDTH-1];
    b_neg = ~op[0] & B[WIDTH-1];
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;

    // Multiply: add multiplicand into the upper half when the multiplier LSB
    // is set, then shift the whole register right, carry included.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};

    // Divide: the shifted upper half needs WIDTH+1 bits, so the bit shifted
    // out of the top takes part in the trial subtraction.
    div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};

    if (op_q[1]) begin
      if (div_diff[WIDTH])
        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      else
        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end

    prod_fix = qneg_q ? -acc_q : acc_q;
    // Divide by zero: quotient stays all-ones. The remainder equals |A|, so
    // applying the remainder sign restores the raw dividend for HI.
    quo_fix  = (qneg_q & ~bzero_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      opnd_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      bzero_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            opnd_q  <= op[1] ? b_mag : a_mag;
            acc_q   <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            cnt_q   <= '0;
            qneg_q  <= a_neg ^ b_neg;
            rneg_q  <= a_neg & op[1];
            bzero_q <= (B == '0);
            busy    <= 1'b1;
            state_q <= S_RUN;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          if (op_q[1]) begin
            lo          <= quo_fix;
            hi          <= rem_fix;
            div_by_zero <= bzero_q;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] A, B, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  int nd;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // inj: 0 none, 1 start+mthi mid-run, 2 mtlo together with start
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz, input int inj);
    logic [31:0] phi, plo;
    int cnt;
    @(negedge clk);
    phi = hi; plo = lo;
    op = o; A = a; B = b; start = 1'b1;
    if (inj == 2) begin mtlo = 1'b1; wdata = 32'hDEAD_BEEF; end
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0;
    chk({tag, " busy_start"}, {31'b0, busy}, 32'd1);
    cnt = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 16) begin
        chk({tag, " hi_hold"}, hi, phi);
        chk({tag, " lo_hold"}, lo, plo);
      end
      if (inj == 1 && i == 5) begin
        start = 1'b1; op = 2'b01; A = 32'h5; B = 32'h3;
        mthi = 1'b1; wdata = 32'h1234;
      end else begin
        start = 1'b0; mthi = 1'b0;
      end
      @(posedge clk); #1;
      if (done) cnt++;
    end
    chk({tag, " early_done"}, 32'(cnt), 32'd0);
    chk({tag, " busy_k32"}, {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    chk({tag, " done"}, {31'b0, done}, 32'd1);
    chk({tag, " busy_end"}, {31'b0, busy}, 32'd0);
    chk({tag, " hi"}, hi, ehi);
    chk({tag, " lo"}, lo, elo);
    chk({tag, " dbz"}, {31'b0, div_by_zero}, {31'b0, edbz});
    @(posedge clk); #1;
    chk({tag, " done_1cyc"}, {31'b0, done}, 32'd0);
    chk({tag, " dbz_1cyc"}, {31'b0, div_by_zero}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; A = '0; B = '0; wdata = '0;
    #22 rst_n = 1'b1;
    #1;
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst dbz", {31'b0, div_by_zero}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0);

    @(negedge clk); mthi = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1; mthi = 1'b0;
    chk("mthi idle", hi, 32'h0000_1234);
    chk("mthi lo_keep", lo, 32'hFFFF_FFEB);
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_CAFE;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    chk("mt both hi", hi, 32'h0000_CAFE);
    chk("mt both lo", lo, 32'h0000_CAFE);

    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 2);
    run_op("divu_inj",  2'b11, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0, 1);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, 0);
    run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        1'b0, 0);
    run_op("div_zero",  2'b10, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("divu_zero", 2'b11, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1, 0);

    // Reset in the middle of RUN
    @(negedge clk); op = 2'b01; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rstmid busy", {31'b0, busy}, 32'd0);
    chk("rstmid hi", hi, 32'd0);
    chk("rstmid lo", lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("rstmid no_done", 32'(nd), 32'd0);
    chk("rstmid busy_after", {31'b0, busy}, 32'd0);

    run_op("multu_after_rst", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, implementing MIPS MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU in the execute stage. Operands come from register-file read_data1 (A) and read_data2 (B).
- HI/LO results feed the register write-back mux, which serves MFHI/MFLO.
- Control logic holds the PC while busy is high.
- Uses one shared 32-iteration shift/add-subtract datapath.

Parameters:
- WIDTH, 32: operand width. HI and LO are each WIDTH bits. The iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  input  WIDTH  multiplicand / dividend (rs).
- B  input  WIDTH  multiplier / divisor (rt).
- mthi  input  1  write wdata into HI.
- mtlo  input  1  write wdata into LO.
- wdata  input  WIDTH  data for MTHI/MTLO.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when HI/LO take a new result.
- div_by_zero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with B==0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst_n low, asynchronous): the state machine goes to IDLE. hi, lo, busy, done, div_by_zero and all internal registers are cleared to 0.
  - Reset mid-operation aborts the operation. No done pulse occurs and HI/LO are 0.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge k:
  - Latch op.
  - Latch |A| and |B| for signed ops (raw values for unsigned ops).
  - Latch the result-sign flags: for MULT/DIV, sign(A) XOR sign(B); for DIV, the remainder sign is sign(A).
  - Clear the accumulator and set count=0. Go to RUN. busy=1 from this edge.
- RUN: one iteration per edge, count increments. At edge k+32 (count reaches WIDTH) go to FIX.
  - Multiply: shift-add. Produces a 64-bit unsigned product.
  - Divide: restoring division. The 64-bit remainder:quotient register shifts left one bit. Subtract the divisor from the upper half; if the result is non-negative, keep it and set quotient bit 1, otherwise restore.
- FIX, edge k+33:
  - Apply two's-complement negation: product (64-bit), quotient, and remainder each per their sign flags.
  - Write results: MULT/MULTU hi=product[63:32], lo=product[31:0]; DIV/DIVU lo=quotient, hi=remainder.
  - done=1 for exactly one cycle. busy=0. Go to IDLE.
- Latency: start accepted at edge k → result visible and done high after edge k+33. A new start can be accepted on the cycle done is high.
- Divide by zero: no trap; the unit runs the full latency.
  - The restoring algorithm naturally yields quotient all-ones and remainder = dividend magnitude.
  - The sign fix is suppressed when B==0, so lo=all-ones and hi=A (raw).
  - div_by_zero pulses with done.
- DIV overflow, -2^(W-1) / -1: lo=0x80000000, hi=0 (wraps, no flag).
- start while busy: ignored. Operands are not re-latched.
- mthi/mtlo:
  - Honoured only in IDLE with start=0. The write takes effect at the next edge; both may assert together.
  - While busy, or when start=1 in the same cycle: ignored (start wins).
- hi/lo hold their value while busy. They change only at the FIX edge, an honoured MT write, or reset.
- op values are fully decoded; no illegal encodings.

Test Plan:
- Unsigned multiply, max operands: MULTU A=0xFFFFFFFF, B=0xFFFFFFFF, start at edge k → busy=1 for 33 cycles; done pulse after edge k+33; hi=0xFFFFFFFE, lo=0x00000001.
- Signed multiply: MULT A=0xFFFFFFFD (-3), B=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Signed and unsigned divide:
  - DIV A=0xFFFFFFF9 (-7), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU A=100, B=7 → lo=14, hi=2.
- Divide edge cases:
  - DIV A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0.
  - DIVU A=5, B=0 → lo=0xFFFFFFFF, hi=5, div_by_zero=1 in the same cycle as done.
- Handshake:
  - start re-asserted with new operands mid-RUN → ignored; the result matches the first operands; exactly one done pulse.
  - mthi=1, wdata=0x1234 while busy → hi unchanged.
  - mthi=1, wdata=0x1234 in IDLE → hi=0x00001234 after one edge.
- Reset mid-operation: rst_n low at cycle 10 of RUN → busy, hi and lo go to 0 immediately (asynchronous); no done pulse after release; a subsequent start runs normally.
